// File: rtl/uart_rx_cfg.sv
// ============================================================================
// uart_rx_cfg : configurable UART receiver (5..9 data bits, parity, 1/2 stop)
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_cfg #(
  parameter int CLOCKS_PER_BIT = 217,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_Data_Valid,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int                CNT_W     = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0]  MID       = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_CLEANUP   = 3'd5,
    S_WAIT_HIGH = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]           hist_q, hist_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 facc_q, facc_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 busy_q, busy_d;

  logic maj, tick, facc_nxt, zero_nxt;

  assign maj  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign tick = (cnt_q == LAST_CNT);
  assign facc_nxt = facc_q | ~maj;
  assign zero_nxt = zero_q & ~maj;

  always_comb begin
    state_d = state_q;
    sync1_d = i_RX_Serial;
    sync2_d = sync1_q;
    hist_d  = {hist_q[1:0], sync2_q};
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    facc_d  = facc_q;
    zero_d  = zero_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        stop_d = 1'b0;
        if (!sync2_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == MID) begin
          cnt_d = '0;
          if (!maj) begin
            state_d = S_DATA;
            par_d   = 1'b0;
            facc_d  = 1'b0;
            zero_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ maj;
          zero_d  = zero_nxt;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = par_q ^ maj;
          zero_d  = zero_nxt;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d  = '0;
          facc_d = facc_nxt;
          zero_d = zero_nxt;
          if (stop_q == LAST_STOP) begin
            // par_q now holds XOR of data and parity bit
            state_d = S_CLEANUP;
            valid_d = 1'b1;
            byte_d  = shift_q;
            perr_d  = (PARITY_MODE == 1) ? ~par_q : (PARITY_MODE == 2) ? par_q : 1'b0;
            ferr_d  = facc_nxt;
            brk_d   = zero_nxt;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEANUP: begin
        state_d = ferr_q ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      facc_q  <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      facc_q  <= facc_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      busy_q  <= busy_d;
    end
  end

  assign o_RX_Data_Valid = valid_q;
  assign o_RX_Byte       = byte_q;
  assign o_Parity_Err    = perr_q;
  assign o_Frame_Err     = ferr_q;
  assign o_Break         = brk_q;
  assign o_Busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// tb_uart_rx_cfg : scoreboard bench for three uart_rx_cfg configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx [3];
  logic       v [3];
  logic       pe [3];
  logic       fe [3];
  logic       bk [3];
  logic       bsy [3];
  logic [7:0] b0, b1;
  logic [6:0] b2;

  int cfg_bits [3] = '{8, 8, 7};
  int cfg_par  [3] = '{0, 2, 1};
  int cfg_stop [3] = '{1, 1, 2};

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .i_RX_Serial(rx[0]), .o_RX_Data_Valid(v[0]), .o_RX_Byte(b0),
    .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(bk[0]), .o_Busy(bsy[0]));
  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .i_RX_Serial(rx[1]), .o_RX_Data_Valid(v[1]), .o_RX_Byte(b1),
    .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(bk[1]), .o_Busy(bsy[1]));
  uart_rx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .i_RX_Serial(rx[2]), .o_RX_Data_Valid(v[2]), .o_RX_Byte(b2),
    .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(bk[2]), .o_Busy(bsy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [8:0] rx_byte(input int i);
    case (i)
      0:       return {1'b0, b0};
      1:       return {1'b0, b1};
      default: return {2'b0, b2};
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor: every valid pulse is matched against the oldest expected frame
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (v[i]) begin
          if (qsize(i) == 0) begin
            check("pulse_expected", 32'(qsize(i)), 32'd1);
          end else begin
            exp_t e;
            e = pop(i);
            check("byte", 32'(rx_byte(i)), 32'(e.d));
            check("parity_err", 32'(pe[i]), 32'(e.pe));
            check("frame_err", 32'(fe[i]), 32'(e.fe));
            check("break", 32'(bk[i]), 32'(e.bk));
          end
        end else begin
          check("flags_idle", {29'd0, pe[i], fe[i], bk[i]}, 32'd0);
        end
      end
    end
  end

  task automatic drive_bit(input int i, input logic b);
    rx[i] = b;
    repeat (CPB) @(negedge clk);
  endtask

  function automatic logic good_parity(input int i, input logic [8:0] d);
    logic [8:0] m;
    m = d & 9'((1 << cfg_bits[i]) - 1);
    return (cfg_par[i] == 1) ? ~^m : ^m;
  endfunction

  task automatic send_frame(input int i, input logic [8:0] d, input logic pbit,
                            input logic [1:0] sb, input int spike);
    logic [8:0] m;
    logic       xr;
    exp_t       e;
    m  = d & 9'((1 << cfg_bits[i]) - 1);
    xr = ^m;
    e.d  = m;
    e.pe = (cfg_par[i] == 0) ? 1'b0 : (cfg_par[i] == 1) ? ((xr ^ pbit) != 1'b1) : ((xr ^ pbit) != 1'b0);
    e.fe = (sb[0] == 1'b0) || (cfg_stop[i] == 2 && sb[1] == 1'b0);
    e.bk = (m == 9'd0) && (cfg_par[i] == 0 || pbit == 1'b0) &&
           ((cfg_stop[i] == 1) ? (sb[0] == 1'b0) : (sb == 2'b00));
    push(i, e);
    drive_bit(i, 1'b0);
    for (int k = 0; k < cfg_bits[i]; k++) begin
      if (k == spike) begin
        rx[i] = m[k];
        repeat (CPB / 2) @(negedge clk);
        rx[i] = ~m[k];
        @(negedge clk);
        rx[i] = m[k];
        repeat (CPB / 2 - 1) @(negedge clk);
      end else begin
        drive_bit(i, m[k]);
      end
    end
    if (cfg_par[i] != 0) drive_bit(i, pbit);
    for (int s = 0; s < cfg_stop[i]; s++) drive_bit(i, sb[s]);
    rx[i] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("drained", 32'(qsize(i)), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rx[i] = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", 32'(v[i]), 32'd0);
      check("rst_byte", 32'(rx_byte(i)), 32'd0);
      check("rst_flags", {29'd0, pe[i], fe[i], bk[i]}, 32'd0);
      check("rst_busy", 32'(bsy[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 clean frame
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
    check("busy_after", 32'(bsy[0]), 32'd0);

    // Even parity good then bad
    send_frame(1, 9'h037, 1'b1, 2'b11, -1);
    send_frame(1, 9'h037, 1'b0, 2'b11, -1);

    // Stop bit low, then a clean frame
    send_frame(0, 9'h03C, 1'b0, 2'b10, -1);
    send_frame(0, 9'h081, 1'b0, 2'b11, -1);

    // Break: line held low for 12 bit times
    begin
      exp_t e;
      e.d = 9'd0; e.pe = 1'b0; e.fe = 1'b1; e.bk = 1'b1;
      push(0, e);
      rx[0] = 1'b0;
      repeat (12 * CPB) @(negedge clk);
      check("break_busy_low_line", 32'(bsy[0]), 32'd1);
      rx[0] = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("break_drained", 32'(qsize(0)), 32'd0);
      check("break_idle", 32'(bsy[0]), 32'd0);
    end
    send_frame(0, 9'h055, 1'b0, 2'b11, -1);

    // Glitch rejection, then a frame with a spike on a data sample
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_idle", 32'(bsy[0]), 32'd0);
    send_frame(0, 9'h00F, 1'b0, 2'b11, 2);

    // Randomised frames across all three configurations
    for (int n = 0; n < 12; n++) begin
      int         i;
      logic [8:0] d;
      logic       pb;
      logic [1:0] sb;
      i  = $urandom_range(0, 2);
      d  = 9'($urandom);
      pb = good_parity(i, d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      send_frame(i, d, pb, sb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1);
    end

    // 7O2: reset in the middle of data bit 3, then a full frame
    send_frame(2, 9'h05A, good_parity(2, 9'h05A), 2'b11, -1);
    drive_bit(2, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(2, (k == 1 || k == 3 || k == 4 || k == 6));
    rx[2] = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(v[2]), 32'd0);
    check("abort_byte", 32'(rx_byte(2)), 32'd0);
    check("abort_flags", {29'd0, pe[2], fe[2], bk[2]}, 32'd0);
    check("abort_busy", 32'(bsy[2]), 32'd0);
    @(negedge clk);
    rx[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_frame(2, 9'h05A, good_parity(2, 9'h05A), 2'b11, -1);

    for (int i = 0; i < 3; i++) check("final_idle", 32'(bsy[i]), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
